// File: rtl/cache_pkg.sv
// Shared definitions for the cache array slice (valid array, tag/data arrays).
//   - FSM state encoding for the flush walker (ST_IDLE, ST_WALK)
//   - default set-index width and associativity, way-mask type
//   - addr_in_range(): set-index bounds check for arrays with MEM_DEPTH < 2**ADDR_WIDTH
package cache_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WALK = 1'b1;

  localparam int CACHE_ADDR_W = 8;
  localparam int CACHE_WAYS   = 2;

  typedef logic [CACHE_WAYS-1:0] way_mask_t;

  // Sets at or above the configured depth do not exist: reads miss, writes drop.
  function automatic logic addr_in_range(input int unsigned a, input int unsigned depth);
    return a < depth;
  endfunction

endpackage

// File: rtl/cache_valid_array_if.sv
// Controller <-> valid-array bus.
//   master : cache controller (drives addr/we/valid_in/flush_req)
//   slave  : cache_valid_array (drives valid_out/flush_busy/flush_done)
// Optional feature macro: CACHE_VMEM_DIRTY_EN adds dirty_in/dirty_out.
interface cache_valid_array_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WAYS       = 2
) ();
  import cache_pkg::*;

  logic [ADDR_WIDTH-1:0] addr;
  logic [WAYS-1:0]       we;
  logic [WAYS-1:0]       valid_in;
  logic [WAYS-1:0]       valid_out;
  logic                  flush_req;
  logic                  flush_busy;
  logic                  flush_done;
`ifdef CACHE_VMEM_DIRTY_EN
  logic [WAYS-1:0]       dirty_in;
  logic [WAYS-1:0]       dirty_out;

  modport master (output addr, we, valid_in, flush_req, dirty_in,
                  input  valid_out, flush_busy, flush_done, dirty_out);
  modport slave  (input  addr, we, valid_in, flush_req, dirty_in,
                  output valid_out, flush_busy, flush_done, dirty_out);
`else
  modport master (output addr, we, valid_in, flush_req,
                  input  valid_out, flush_busy, flush_done);
  modport slave  (input  addr, we, valid_in, flush_req,
                  output valid_out, flush_busy, flush_done);
`endif

endinterface

// File: rtl/cache_flush_walker.sv
// Flush walker: sequential invalidate of every set, one set per cycle.
//   clk, rst      : clock, synchronous active-high reset (reset starts a walk)
//   flush_req_i   : level-sampled flush request, honoured only when idle
//   flush_busy_o  : walk in progress
//   flush_done_o  : one-cycle pulse after the last set has been cleared
//   clr_en_o      : clear mem[clr_idx_o] at this edge
//   clr_idx_o     : set being cleared
module cache_flush_walker
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req_i,
  output logic                  flush_busy_o,
  output logic                  flush_done_o,
  output logic                  clr_en_o,
  output logic [ADDR_WIDTH-1:0] clr_idx_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req_i) begin
          state_d = ST_WALK;
          idx_d   = '0;
        end
      end
      ST_WALK: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_WALK;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WALK;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign flush_busy_o = (state_q == ST_WALK);
  assign flush_done_o = done_q;
  // While rst is held the walker sits at idx 0, so set 0 is scrubbed every reset cycle;
  // forcing idx 0 under rst also covers the very first reset edge, when state is unknown.
  assign clr_en_o     = rst | flush_busy_o;
  assign clr_idx_o    = rst ? '0 : idx_q;

endmodule

// File: rtl/cache_valid_array.sv
// Per-set, per-way valid-bit store with sequential flush walk.
//   clk, rst : clock, synchronous active-high reset (reset triggers a full walk)
//   bus      : cache_valid_array_if.slave
//                addr/we/valid_in write port, valid_out combinational read,
//                flush_req/flush_busy/flush_done walk handshake
// Optional feature macro: CACHE_VMEM_DIRTY_EN adds a parallel dirty-bit array
// (dirty_in written with valid_in, dirty_out read and forced like valid_out).
module cache_valid_array
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CACHE_ADDR_W,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int WAYS       = CACHE_WAYS
) (
  input logic               clk,
  input logic               rst,
  cache_valid_array_if.slave bus
);

  logic                  busy;
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  in_rng;
  logic                  wr_ok;
  logic                  force0;
  logic [WAYS-1:0]       rd_v;

  cache_flush_walker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_walker (
    .clk          (clk),
    .rst          (rst),
    .flush_req_i  (bus.flush_req),
    .flush_busy_o (busy),
    .flush_done_o (bus.flush_done),
    .clr_en_o     (clr_en),
    .clr_idx_o    (clr_idx)
  );

  assign bus.flush_busy = busy;
  assign in_rng = addr_in_range(32'(bus.addr), MEM_DEPTH);
  // clr_en covers both reset and walk, so writes only land when idle and out of reset.
  assign wr_ok  = !clr_en && in_rng;
  // Force a miss while the array is being scrubbed or for a non-existent set.
  assign force0 = busy || !in_rng;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
      if (clr_en)                   mem_q[clr_idx]  <= 1'b0;
      else if (wr_ok && bus.we[w])  mem_q[bus.addr] <= bus.valid_in[w];
    end

    assign rd_v[w] = mem_q[bus.addr];
  end

  assign bus.valid_out = force0 ? '0 : rd_v;

`ifdef CACHE_VMEM_DIRTY_EN
  logic [WAYS-1:0] rd_d;

  for (genvar w = 0; w < WAYS; w++) begin : g_dirty
    logic dirty_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
      if (clr_en)                   dirty_q[clr_idx]  <= 1'b0;
      else if (wr_ok && bus.we[w])  dirty_q[bus.addr] <= bus.dirty_in[w];
    end

    assign rd_d[w] = dirty_q[bus.addr];
  end

  assign bus.dirty_out = force0 ? '0 : rd_d;
`endif

endmodule
